// File: rtl/fifo_stream_adapter.sv
// -----------------------------------------------------------------------------
// fifo_stream_adapter
//
// Turns the read port of a standard (non first-word-fall-through) FIFO, whose
// data appears one clock after the read strobe, into a valid/ready stream.
// A two-entry skid buffer absorbs the read latency so the stream can run at
// one word per clock once primed.
//
// Ports
//   clk         single clock for all logic
//   rst         synchronous, active-high reset
//   fifo_dout   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  FIFO read strobe
//   flush       discard buffered and in-flight words
//   m_data      stream data (oldest held word)
//   m_valid     stream data valid
//   m_ready     downstream accept
//   level       words currently held (0..2)
//   xfer_count  completed-handshake counter
//
// Optional feature
//   FIFO_STREAM_XFER_CNT_EN  when defined, xfer_count counts pops (wrapping
//                            16 bits); otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module fifo_stream_adapter #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic             flush,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       level,
  output logic [15:0]      xfer_count
);

  // Encoding doubles as the fill level.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] head_q, head_d;   // oldest word, drives m_data
  logic [WIDTH-1:0] tail_q, tail_d;   // second word, valid only in ST_TWO
  logic             pop;
  logic             capture;
  logic             capture_to_tail;
  logic [2:0]       occupancy;

  // Output and handshake decode. Outputs are masked while rst is high so the
  // stream looks empty even before the first reset edge has landed.
  always_comb begin
    m_valid   = !rst && (state_q != ST_EMPTY);
    level     = rst ? 2'd0 : logic'(1'b0) ? 2'd0 : state_q;
    m_data    = head_q;
    pop       = m_valid && m_ready;
    // A returning word is dropped when flush coincides with its arrival.
    capture   = inflight_q && !flush;
    // Words held plus the one on its way, minus the one leaving now: a new
    // read is only safe if that leaves room for its data next cycle.
    occupancy = {1'b0, level} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en = !fifo_empty && !flush && !rst && (occupancy < 3'd2);
  end

  // Next-state and buffer update.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    inflight_d = fifo_rd_en;
    head_d     = head_q;
    tail_d     = tail_q;

    // Captured word lands behind whatever survives this edge's pop.
    capture_to_tail = (state_q == ST_TWO) || ((state_q == ST_ONE) && !pop);

    if (pop) begin
      head_d = tail_q;
    end
    if (capture) begin
      if (capture_to_tail) tail_d = fifo_dout;
      else                 head_d = fifo_dout;
    end

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case ({capture, pop})
        2'b10:   state_d = (state_q == ST_EMPTY) ? ST_ONE : ST_TWO;
        2'b01:   state_d = (state_q == ST_TWO)   ? ST_ONE : ST_EMPTY;
        default: state_d = state_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
    end
  end

  // NOTE: tail is pure data storage qualified by state, so it carries no reset.
  always_ff @(posedge clk) begin
    tail_q <= tail_d;
  end

`ifdef FIFO_STREAM_XFER_CNT_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  // Flush does not clear the counter; a pop during flush still counts.
  always_comb begin
    xfer_cnt_d = pop ? (xfer_cnt_q + 16'd1) : xfer_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) xfer_cnt_q <= 16'h0000;
    else     xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_count = xfer_cnt_q;
`else
  assign xfer_count = 16'h0000;
`endif

endmodule

// File: doc/fifo_stream_adapter.md
FIFO_STREAM_ADAPTER -- requirements
Module: fifo_stream_adapter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 9, giving the data width in bits (legal 9, 18, 36).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous to clk and active-high.
REQ-004 The block SHALL have port fifo_dout, input, WIDTH bits: FIFO read data, valid one clk after fifo_rd_en is high.
REQ-005 The block SHALL have port fifo_empty, input, 1 bit: FIFO empty flag.
REQ-006 The block SHALL have port fifo_rd_en, output, 1 bit: FIFO read strobe.
REQ-007 The block SHALL have port flush, input, 1 bit: discard all buffered and in-flight words.
REQ-008 The block SHALL have port m_data, output, WIDTH bits: stream data.
REQ-009 The block SHALL have port m_valid, output, 1 bit: stream data valid.
REQ-010 The block SHALL have port m_ready, input, 1 bit: downstream accept.
REQ-011 The block SHALL have port level, output, 2 bits: number of words held (0..2).
REQ-012 The block SHALL have port xfer_count, output, 16 bits: handshake counter (see Configuration).

Function
REQ-013 The block SHALL convert the non-FWFT FIFO read port (1-cycle read latency) into a valid/ready stream using a 2-entry buffer.
REQ-014 Buffer state SHALL be one of EMPTY (level 0), ONE (level 1) or TWO (level 2); level SHALL equal the state encoding.
REQ-015 m_valid SHALL be high exactly when state is ONE or TWO; m_data SHALL be the oldest held word.
REQ-016 pop is m_valid && m_ready; a word SHALL leave the buffer on every clk edge where pop is high.
REQ-017 A register inflight SHALL be set on the edge after fifo_rd_en is high and cleared otherwise; when inflight is high, fifo_dout SHALL be written into the buffer on that edge.
REQ-018 fifo_rd_en SHALL be high when !fifo_empty && !flush && !rst && (level + inflight - pop) < 2.
REQ-019 With m_ready held high and the FIFO non-empty, the block SHALL sustain one word per clk after a 2-cycle fill latency (fifo_rd_en at cycle 0, m_valid at cycle 2).
REQ-020 Capture and pop on the same edge SHALL leave level unchanged and preserve word order.
REQ-021 Capture SHALL never occur in state TWO without a simultaneous pop; REQ-018 guarantees this, and the bench SHALL assert it.
REQ-022 m_data and m_valid SHALL be held stable while m_valid && !m_ready.
REQ-023 flush high SHALL, on that edge, set state EMPTY, force fifo_rd_en low in that cycle, and drop any word returning in the following cycle (inflight cleared, no capture).
REQ-024 A pop coinciding with flush SHALL count as a completed transfer.
REQ-025 fifo_empty rising while inflight is high SHALL NOT cancel the in-flight capture.

Reset
REQ-026 When rst is high on a clk edge, the block SHALL set state EMPTY, inflight 0 and m_data 0, and xfer_count SHALL be 0.
REQ-027 During rst, the block SHALL drive fifo_rd_en 0, m_valid 0 and level 0; a word in flight when rst asserts SHALL be discarded.
REQ-028 flush SHALL NOT clear xfer_count.

Configuration
REQ-029 With macro FIFO_STREAM_XFER_CNT_EN defined, xfer_count SHALL increment by 1 on each pop, wrapping 16'hFFFF to 16'h0000.
REQ-030 Without FIFO_STREAM_XFER_CNT_EN, xfer_count SHALL be constant 0 and no counter register SHALL be inferred.

Verification
REQ-031 Bench SHALL cover: FIFO preloaded with 0x001,0x002,0x003 and m_ready=1 -> fifo_rd_en at cycles 0,1,2; m_data 0x001,0x002,0x003 at cycles 2,3,4; level returns to 0.
REQ-032 Bench SHALL cover: 5 words, m_ready=0 -> exactly 2 reads issued, level=2, m_data=first word held stable; m_ready=1 -> remaining 5 delivered in order, no loss or duplication.
REQ-033 Bench SHALL cover: flush asserted one cycle after a read strobe with level=1 -> next cycle level=0, m_valid=0, the returning word is dropped, and the following word is delivered first.
REQ-034 Bench SHALL cover: m_ready toggling every cycle over 100 random words -> output order matches input order and fifo_rd_en is never high while fifo_empty is high.
REQ-035 Bench SHALL cover: rst asserted mid-stream with level=2 and a read in flight -> next cycle m_valid=0, level=0, xfer_count=0, m_data=0.
REQ-036 Bench SHALL cover: with FIFO_STREAM_XFER_CNT_EN, xfer_count preset by 65535 transfers plus 2 more -> reads 0x0001; without the macro -> xfer_count=0 throughout.
